// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with in-block CSRRW/CSRRS/CSRRC, illegal-access
// detection, trap/interrupt entry, mret, and cycle/instret/HPM counters.
// Optional: CSR_VECTORED_EN enables vectored interrupt dispatch via mtvec[0].
module csr_unit #(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter int          COUNTER_W = 64,
    parameter int          NUM_HPM   = 4,
    parameter logic [31:0] MISA_VAL  = 32'h40000100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic               instr_retire,
    input  logic [NUM_HPM-1:0] hpm_event,
    input  logic               trap_req,
    input  logic [3:0]         trap_cause,
    input  logic [31:0]        trap_pc,
    input  logic [31:0]        trap_val,
    input  logic               mret,
    input  logic               ext_irq,
    input  logic               sw_irq,
    input  logic               tmr_irq,
    output logic               irq_take,
    output logic [31:0]        trap_vector,
    output logic [31:0]        mepc_out
);
    // only the three M-mode interrupt bits exist in mie/mip
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;
    // CY, IR and one bit per HPM counter; bit 1 (TM) is hardwired to 0
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic                              mst_mie, mst_mpie;
    logic [31:0]                       mie_bits, mip_bits, mscratch, mcause, mtval, mcountinh;
    logic [29:0]                       mtvec_base, mepc_word;
    logic                              mtvec_mode;
    logic [COUNTER_W-1:0]              mcycle, minstret;
    logic [NUM_HPM-1:0][COUNTER_W-1:0] hpm_cnt;

    logic [31:0] rd_val, wval, pending, irq_cause, mstatus_rd;
    logic        hit, is_wr, csr_we, irq_any;

    // counters are handled through a 64-bit view so COUNTER_W = 32 needs no special case
    function automatic logic [31:0] lo32(input logic [COUNTER_W-1:0] c);
        logic [63:0] t;
        t = 64'(c);
        return t[31:0];
    endfunction

    function automatic logic [31:0] hi32(input logic [COUNTER_W-1:0] c);
        logic [63:0] t;
        t = 64'(c);
        return t[63:32];
    endfunction

    function automatic logic [COUNTER_W-1:0] cnt_wr(input logic [COUNTER_W-1:0] c,
                                                    input logic hi, input logic [31:0] v);
        logic [63:0] t;
        t = 64'(c);
        if (hi) t[63:32] = v;
        else    t[31:0]  = v;
        return t[COUNTER_W-1:0];
    endfunction

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

    // old-value read mux and address decode
    always_comb begin
        rd_val = 32'h0;
        hit    = 1'b1;
        case (csr_addr)
            12'h300: rd_val = mstatus_rd;
            12'h301: rd_val = MISA_VAL;
            12'h304: rd_val = mie_bits;
            12'h305: rd_val = {mtvec_base, 1'b0, mtvec_mode};
            12'h340: rd_val = mscratch;
            12'h341: rd_val = {mepc_word, 2'b00};
            12'h342: rd_val = mcause;
            12'h343: rd_val = mtval;
            12'h344: rd_val = mip_bits;
            12'h320: rd_val = mcountinh;
            12'hB00, 12'hC00: rd_val = lo32(mcycle);
            12'hB80, 12'hC80: rd_val = hi32(mcycle);
            12'hB02, 12'hC02: rd_val = lo32(minstret);
            12'hB82, 12'hC82: rd_val = hi32(minstret);
            12'hF14: rd_val = HART_ID;
            default: hit = 1'b0;
        endcase
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_addr == 12'(32'hB03 + i)) begin
                rd_val = lo32(hpm_cnt[i]);
                hit    = 1'b1;
            end
            if (csr_addr == 12'(32'hB83 + i)) begin
                rd_val = hi32(hpm_cnt[i]);
                hit    = 1'b1;
            end
        end
    end

    // read-modify-write value and legality
    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rd_val | csr_wdata;
            2'b11:   wval = rd_val & ~csr_wdata;
            default: wval = rd_val;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never counts as a write
    assign is_wr       = (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != 32'h0));
    assign csr_illegal = (csr_op != 2'b00) && (!hit || (is_wr && csr_addr[11:10] == 2'b11));
    assign csr_rdata   = (csr_op == 2'b00) ? 32'h0 : rd_val;
    assign csr_we      = is_wr && !csr_illegal && !stall && !trap_req && !irq_take && !mret;

    // interrupt arbitration: ext > sw > tmr
    assign pending   = mip_bits & mie_bits;
    assign irq_any   = pending[11] | pending[7] | pending[3];
    assign irq_take  = mst_mie && irq_any && !stall && !trap_req;
    assign irq_cause = pending[11] ? 32'h8000_000B :
                       pending[3]  ? 32'h8000_0003 : 32'h8000_0007;
    assign mepc_out  = {mepc_word, 2'b00};

`ifdef CSR_VECTORED_EN
    // vectored dispatch only for interrupts; synchronous traps land on base
    assign trap_vector = (mtvec_mode && irq_take) ?
                         ({mtvec_base, 2'b00} + {26'b0, irq_cause[3:0], 2'b00}) :
                         {mtvec_base, 2'b00};
`else
    assign mtvec_mode  = 1'b0;
    assign trap_vector = {mtvec_base, 2'b00};
`endif

    // architectural state: one prioritised action per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_bits   <= 32'h0;
            mip_bits   <= 32'h0;
            mscratch   <= 32'h0;
            mcause     <= 32'h0;
            mtval      <= 32'h0;
            mcountinh  <= 32'h0;
            mtvec_base <= 30'h0;
            mepc_word  <= 30'h0;
`ifdef CSR_VECTORED_EN
            mtvec_mode <= 1'b0;
`endif
        end else begin
            mip_bits <= {20'b0, ext_irq, 3'b0, tmr_irq, 3'b0, sw_irq, 3'b0};
            if (trap_req) begin
                mepc_word <= trap_pc[31:2];
                mcause    <= {28'b0, trap_cause};
                mtval     <= trap_val;
                mst_mpie  <= mst_mie;
                mst_mie   <= 1'b0;
            end else if (irq_take) begin
                mepc_word <= trap_pc[31:2];
                mcause    <= irq_cause;
                mtval     <= 32'h0;
                mst_mpie  <= mst_mie;
                mst_mie   <= 1'b0;
            end else if (mret && !stall) begin
                mst_mie   <= mst_mpie;
                mst_mpie  <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    12'h300: begin
                        mst_mie  <= wval[3];
                        mst_mpie <= wval[7];
                    end
                    12'h304: mie_bits  <= wval & IRQ_MASK;
                    12'h305: begin
                        mtvec_base <= wval[31:2];
`ifdef CSR_VECTORED_EN
                        mtvec_mode <= wval[0];
`endif
                    end
                    12'h340: mscratch  <= wval;
                    12'h341: mepc_word <= wval[31:2];
                    12'h342: mcause    <= wval;
                    12'h343: mtval     <= wval;
                    12'h320: mcountinh <= wval & INH_MASK;
                    default: ;
                endcase
            end
        end
    end

    logic cyc_wr_lo, cyc_wr_hi, ret_wr_lo, ret_wr_hi;
    assign cyc_wr_lo = csr_we && (csr_addr == 12'hB00);
    assign cyc_wr_hi = csr_we && (csr_addr == 12'hB80);
    assign ret_wr_lo = csr_we && (csr_addr == 12'hB02);
    assign ret_wr_hi = csr_we && (csr_addr == 12'hB82);

    // mcycle: free-running unless inhibited; a CSR write wins over the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        mcycle <= '0;
        else if (cyc_wr_lo || cyc_wr_hi) mcycle <= cnt_wr(mcycle, cyc_wr_hi, wval);
        else if (!mcountinh[0])         mcycle <= mcycle + COUNTER_W'(1);
    end

    // minstret: counts retirements
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         minstret <= '0;
        else if (ret_wr_lo || ret_wr_hi) minstret <= cnt_wr(minstret, ret_wr_hi, wval);
        else if (instr_retire && !mcountinh[2]) minstret <= minstret + COUNTER_W'(1);
    end

    for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
        localparam logic [11:0] ADDR_LO = 12'(32'hB03 + g);
        localparam logic [11:0] ADDR_HI = 12'(32'hB83 + g);
        logic                 wr_lo, wr_hi;
        logic [COUNTER_W-1:0] cnt;
        assign wr_lo      = csr_we && (csr_addr == ADDR_LO);
        assign wr_hi      = csr_we && (csr_addr == ADDR_HI);
        assign hpm_cnt[g] = cnt;

        // event counter g
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                cnt <= '0;
            else if (wr_lo || wr_hi) cnt <= cnt_wr(cnt, wr_hi, wval);
            else if (hpm_event[g] && !mcountinh[3+g]) cnt <= cnt + COUNTER_W'(1);
        end
    end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised successor of the machine-mode CSR file.
- Adds CSRRW/CSRRS/CSRRC read-modify-write inside the block, illegal-access detection, mtval capture, and prioritised interrupt arbitration with trap-vector generation.
- Adds minstret, mcountinhibit, a configurable bank of HPM event counters, and mhartid.
- Sits in the execute stage; the pipeline consumes `csr_rdata`, `csr_illegal`, `irq_take` and `trap_vector`.

Parameters:
- HART_ID, 0: value returned by mhartid (0xF14).
- COUNTER_W, 64: width of mcycle, minstret and HPM counters (legal 32..64).
- NUM_HPM, 4: number of mhpmcounter3.. counters (legal 1..8).
- MISA_VAL, 32'h40000100: constant value returned by misa.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  pipeline/cache stall; blocks CSR writes, mret and interrupt take.
- csr_addr  in  12  CSR address.
- csr_op  in  2  operation: 00 none, 01 RW, 10 RS, 11 RC.
- csr_wdata  in  32  rs1 or zimm operand.
- csr_rdata  out  32  old CSR value (combinational).
- csr_illegal  out  1  illegal access (combinational).
- instr_retire  in  1  one instruction retired this cycle.
- hpm_event  in  NUM_HPM  per-counter event strobes.
- trap_req  in  1  synchronous exception.
- trap_cause  in  4  exception code.
- trap_pc  in  32  PC saved to mepc on trap or interrupt.
- trap_val  in  32  value written to mtval.
- mret  in  1  mret executing.
- ext_irq, sw_irq, tmr_irq  in  1 each  level interrupt lines.
- irq_take  out  1  interrupt accepted this cycle.
- trap_vector  out  32  fetch target on trap or interrupt.
- mepc_out  out  32  mret return address.

Behaviour:
- Reset values:
  - mstatus = 0x1800; all other writable CSRs = 0; counters = 0.
  - Outputs follow combinationally from these: csr_rdata = 0 when csr_op = 00; irq_take = 0; trap_vector = 0; mepc_out = 0.
- Implemented CSRs:
  - 0x300 mstatus, 0x301 misa, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip, 0x320 mcountinhibit.
  - 0xB00/0xB80 mcycle/h, 0xB02/0xB82 minstret/h, 0xB03+i/0xB83+i mhpmcounter(3+i)/h.
  - 0xC00/0xC80/0xC02/0xC82 read-only shadows of the cycle and instret counters; 0xF14 mhartid.
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - RS/RC with wdata = 0 perform no write and are never illegal for being read-only.
- csr_illegal = 1 when csr_op != 00 and either:
  - the address is unimplemented, or
  - the access is a write to addr[11:10] = 11.
  - An illegal access writes nothing.
- Counter high halves read counter[COUNTER_W-1:32] zero-extended; they read 0 when COUNTER_W = 32.
- Increments, when not inhibited by mcountinhibit:
  - mcycle: every cycle; mcountinhibit bit 0 inhibits.
  - minstret: on instr_retire; bit 2 inhibits.
  - HPM counter i: on hpm_event[i]; bit 3+i inhibits.
  - Increments continue during stall.
  - A CSR write to a counter half overrides that cycle's increment of that counter.
  - Counters wrap to 0.
- mip:
  - Bits 3/7/11 are registered copies of sw/tmr/ext_irq each cycle.
  - Software writes to these bits are ignored.
- Interrupts:
  - pending = mip & mie.
  - irq_take = mstatus.MIE & |pending[11,7,3] & !stall & !trap_req.
  - Priority: ext (cause 0x8000000B) > sw (0x80000003) > tmr (0x80000007).
- Event priority per cycle (one action):
  1. trap_req: mepc = trap_pc, mcause = {28'b0, trap_cause}, mtval = trap_val, MPIE = MIE, MIE = 0. Taken regardless of stall.
  2. irq_take: mepc = trap_pc, mcause = irq cause, mtval = 0, MPIE = MIE, MIE = 0.
  3. mret & !stall: MIE = MPIE, MPIE = 1.
  4. Legal CSR write & !stall.
- trap_vector = {mtvec[31:2], 2'b00} (direct mode).
- mepc_out = {mepc[31:2], 2'b00}.
- WARL fields:
  - mepc[1:0] always reads 0.
  - mtvec bit 1 reads 0.
  - mcountinhibit bit 1 reads 0.
- Reset asserted mid-operation returns every register to its reset value immediately; no partial write survives.

Optional Feature:
- Macro: CSR_VECTORED_EN.
- Defined:
  - mtvec[0] is writable.
  - When mtvec[0] = 1 and irq_take = 1: trap_vector = base + 4 × (cause[3:0]).
  - Synchronous traps always use base.
- Undefined:
  - mtvec[1:0] always read 0.
  - All traps go to base.

Test Plan:
- Reset, then read 0x300, 0xF14, 0xB00 -> 0x00001800, HART_ID, 0. Next cycle mcycle reads 1.
- Write mscratch = 0xF0F0_0000 via RW; RS 0x0000_000F; RC 0xF000_0000 -> csr_rdata returns the old value each time; final value 0x00F0_000F.
- RW to 0xC00 -> csr_illegal = 1, no change. RS 0 to 0xC00 -> csr_illegal = 0. Read 0x7C0 -> csr_illegal = 1.
- mie = 0x888, MIE = 1, tmr_irq and ext_irq asserted in the same cycle, trap_pc = 0x100 -> after mip latches, irq_take = 1, mcause = 0x8000000B, mepc = 0x100, MIE = 0. Same stimulus with stall = 1 -> no take.
- mcountinhibit = 0x5 -> mcycle and minstret freeze over 10 cycles with instr_retire = 1. Write mcycle = 0xFFFFFFFF, mcycleh = 0, then clear inhibit -> next read of mcycleh returns 1.
- With CSR_VECTORED_EN defined: mtvec = 0x1001, ext interrupt taken -> trap_vector = 0x102C. trap_req with cause 2 -> trap_vector = 0x1000.
